inst_j_enc: RTL and testbench

- Sequential JAL encoder: the writer-side counterpart of the J-type instruction decoder.
- Accepts a jump target address and a destination register over a valid/ready handshake.
- Computes the PC-relative offset against an internal write-address counter and scrambles it into the RV32I J-type immediate layout.
- Queues encoded words, each tagged with its instruction-memory address, in a small output FIFO feeding the program loader / instruction-memory write port.

---
 rtl/inst_pkg.sv | 27 ++
 rtl/inst_fifo.sv | 50 +++++
 rtl/inst_j_enc.sv | 99 +++++++++
 tb/tb_inst_j_enc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared instruction-encoding package.
// Holds the RV32I opcode constants used by the encoders and decoders, the
// J-type immediate bit positions, and a packing helper that builds a J-type
// word from a 21-bit immediate and a destination register.
package inst_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Where each immediate field lands in the J-type word
  localparam int J_IMM20_POS   = 31;
  localparam int J_IMM10_1_LO  = 21;
  localparam int J_IMM11_POS   = 20;
  localparam int J_IMM19_12_LO = 12;
  localparam int RD_LO         = 7;

  // imm[0] is implicitly zero in the J format and is dropped here.
  function automatic logic [31:0] j_pack(input logic [20:0] imm,
                                         input logic [4:0]  rd,
                                         input logic [6:0]  opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears storage too)
//   i_push, i_data    write side; caller never pushes when full
//   i_pop             read side; caller never pops when empty
//   o_data            head entry (combinational, visible the cycle after push)
//   o_count           occupancy 0..DEPTH
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_count
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/inst_j_enc.sv
// Sequential JAL encoder.
// Takes an absolute jump target + rd, forms the PC-relative offset against an
// internal write-address counter, packs it as an RV32I JAL word and queues
// {addr, word} in a small output FIFO for the instruction-memory loader.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           request handshake (in_ready is combinational)
//   in_target, in_rd            absolute target address, link register
//   pc_load, pc_load_val        overwrite the write address (word aligned)
//   out_valid/out_ready         FIFO head handshake
//   out_word, out_addr          encoded word and its destination address
//   err                         one-cycle pulse on a rejected request
//   pc                          address the next word will be written to
// Build option INST_J_ENC_RANGE_CHECK_EN: when defined, requests whose
// offset is odd or does not fit signed 21 bits are dropped and flagged on
// err; when undefined the offset is truncated and every request is encoded.
module inst_j_enc
  import inst_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter logic [6:0]  OPCODE_JAL = OPC_JAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_target,
  input  logic [4:0]  in_rd,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [31:0] pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] r_pc;
  logic [31:0] w_offset;
  logic        w_ok;
  logic        w_accept, w_push, w_pop;
  logic [31:0] w_word;
  logic [63:0] w_head;
  logic [AW:0] w_count;

  assign w_offset = in_target - r_pc;

`ifdef INST_J_ENC_RANGE_CHECK_EN
  // Fits signed 21 bits: all bits above 20 replicate bit 20; must be even.
  assign w_ok = !w_offset[0] && (w_offset[31:20] == {12{w_offset[20]}});
`else
  assign w_ok = 1'b1;
`endif

  // pc_load blocks accepts so the offset is never computed against a PC
  // that is changing in the same cycle.
  assign in_ready = (w_count != (AW+1)'(DEPTH)) && !pc_load;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_ok;
  assign w_pop    = out_valid && out_ready;
  assign w_word   = j_pack(w_offset[20:0], in_rd, OPCODE_JAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_pc <= BASE_ADDR;
    else if (pc_load) r_pc <= {pc_load_val[31:2], 2'b00};
    else if (w_push)  r_pc <= r_pc + 32'd4;
  end

`ifdef INST_J_ENC_RANGE_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_accept && !w_ok;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  inst_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_pc, w_word}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign out_valid = (w_count != '0);
  assign out_addr  = w_head[63:32];
  assign out_word  = w_head[31:0];
  assign pc        = r_pc;

endmodule

// File: tb/tb_inst_j_enc.sv
// Bench for inst_j_enc: directed steps followed by a random phase, all
// checked against a queue-based reference model of the encoder.
module tb_inst_j_enc;
  localparam int DEPTH = 2;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_target = 0;
  logic [4:0]  in_rd = 0;
  logic        pc_load = 0;
  logic [31:0] pc_load_val = 0;
  logic        out_valid, out_ready = 0;
  logic [31:0] out_word, out_addr, pc;
  logic        err;

  int n_chk = 0, n_fail = 0;

  // model state
  logic [63:0] q[$];
  logic [31:0] mpc;
  logic        merr;

  inst_j_enc #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .in_rd(in_rd), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err(err), .pc(pc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding computed straight from the J-type field layout.
  function automatic logic [31:0] ref_word(input logic [31:0] off, input logic [4:0] rd);
    return (((off >> 20) & 32'h1) << 31) | (((off >> 1) & 32'h3FF) << 21) |
           (((off >> 11) & 32'h1) << 20) | (((off >> 12) & 32'hFF) << 12) |
           (32'(rd) << 7) | 32'h6F;
  endfunction

  function automatic bit ref_ok(input logic [31:0] off);
`ifdef INST_J_ENC_RANGE_CHECK_EN
    int signed s;
    s = $signed(off);
    return (off[0] == 1'b0) && (s >= -(1 << 20)) && (s <= (1 << 20) - 2);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_reset();
    q.delete();
    mpc  = 32'h0;
    merr = 1'b0;
  endfunction

  // Inputs already driven; check outputs, take one edge, advance the model.
  task automatic cycle();
    bit rdy, popv;
    logic [31:0] off;
    #1;
    rdy  = (q.size() != DEPTH) && !pc_load;
    popv = out_ready && (q.size() > 0);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_word", out_word, q[0][31:0]);
      chk("out_addr", out_addr, q[0][63:32]);
    end
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("pc", pc, mpc);
    chk("err", 32'(err), 32'(merr));
    @(posedge clk);
    merr = 1'b0;
    if (popv) void'(q.pop_front());
    if (in_valid && rdy) begin
      off = in_target - mpc;
      if (ref_ok(off)) begin
        q.push_back({mpc, ref_word(off, in_rd)});
        mpc = mpc + 32'd4;
      end else merr = 1'b1;
    end
    if (pc_load) mpc = pc_load_val & 32'hFFFF_FFFC;
    #1;
  endtask

  task automatic idle();
    in_valid = 0; pc_load = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    #1;
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] off;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // basic forward jump
    out_ready = 1; in_valid = 1; in_target = 32'h10; in_rd = 5'd1;
    cycle();
    idle();
    chk("jal_fwd_word", out_word, 32'h0100_00EF);
    chk("jal_fwd_addr", out_addr, 32'h0);
    chk("jal_fwd_pc", pc, 32'h4);
    cycle();

    // backward jump from pc=8
    pc_load = 1; pc_load_val = 32'h8;
    cycle();
    idle();
    in_valid = 1; in_target = 32'h0; in_rd = 5'd5;
    cycle();
    idle();
    chk("jal_back_word", out_word, 32'hFF9F_F2EF);
    chk("jal_back_addr", out_addr, 32'h8);
    chk("jal_back_pc", pc, 32'd12);
    cycle();

    // back-pressure: three requests, only two fit
    do_reset();
    out_ready = 0; in_valid = 1; in_rd = 5'd3;
    in_target = 32'h100; cycle();
    in_target = 32'h200; cycle();
    in_target = 32'h300;
    chk("bp_full_ready", 32'(in_ready), 32'h0);
    cycle();
    chk("bp_hold_word", out_word, ref_word(32'h100, 5'd3));
    chk("bp_hold_addr", out_addr, 32'h0);
    out_ready = 1;
    cycle();
    chk("bp_second_addr", out_addr, 32'h4);
    cycle();
    idle();
    chk("bp_third_addr", out_addr, 32'h8);
    cycle();
    cycle();

`ifdef INST_J_ENC_RANGE_CHECK_EN
    // out-of-range and odd offsets are rejected
    do_reset();
    in_valid = 1; in_target = 32'h0010_0000; in_rd = 5'd2;
    cycle();
    idle();
    chk("rc_range_err", 32'(err), 32'h1);
    chk("rc_range_valid", 32'(out_valid), 32'h0);
    chk("rc_range_pc", pc, 32'h0);
    cycle();
    chk("rc_err_pulse", 32'(err), 32'h0);
    in_valid = 1; in_target = 32'h3;
    cycle();
    idle();
    chk("rc_odd_err", 32'(err), 32'h1);
    cycle();
`else
    // without range check, the same request encodes a truncated offset
    do_reset();
    in_valid = 1; in_target = 32'h0010_0000; in_rd = 5'd2;
    cycle();
    idle();
    chk("nrc_err", 32'(err), 32'h0);
    chk("nrc_pc", pc, 32'h4);
    cycle();
`endif

    // pc_load with a pending request
    pc_load = 1; pc_load_val = 32'h0000_1002; in_valid = 1; in_target = 32'h1100;
    #1;
    chk("ld_ready", 32'(in_ready), 32'h0);
    cycle();
    chk("ld_pc", pc, 32'h1000);
    pc_load = 0;
    cycle();
    idle();
    chk("ld_addr", out_addr, 32'h1000);
    cycle();

    // async reset with a full FIFO
    out_ready = 0; in_valid = 1; in_target = 32'h40;
    cycle(); cycle();
    idle();
    cycle();
    chk("pre_rst_full", 32'(out_valid), 32'h1);
    do_reset();
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      pc_load   = ($urandom_range(0, 15) == 0);
      pc_load_val = $urandom;
      in_rd     = 5'($urandom);
      case ($urandom_range(0, 4))
        0: off = 32'($urandom_range(0, 4096)) << 1;
        1: off = -(32'($urandom_range(0, 4096)) << 1);
        2: off = 32'h000F_FFFE + 32'($urandom_range(0, 4)) - 32'd2;
        3: off = 32'hFFF0_0000 + 32'($urandom_range(0, 4)) - 32'd2;
        default: off = $urandom;
      endcase
      in_target = mpc + off;
      cycle();
    end
    idle();
    out_ready = 1;
    cycle(); cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
